instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 33 +++
 rtl/instr_loader.sv | 118 +++++++++++
 tb/tb_instr_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_if
//  Description : Program byte-stream, instruction-memory write and status bundle
//                shared by instr_loader and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [5:0]  word_count;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_en, wr_addr, wr_data,
        output cpu_hold, load_done, load_err, word_count
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_en, wr_addr, wr_data,
        input  cpu_hold, load_done, load_err, word_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Assembles a big-endian byte stream into 32-bit instructions and
//                writes up to 32 words into instruction memory while holding
//                the CPU. Define INSTR_LOADER_OPCODE_CHECK_EN to reject words
//                whose opcode field [31:15] is above 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [4:0] c_last_addr = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_byte_idx;
    logic [1:0]  w_byte_idx_nxt;
    logic [4:0]  r_word_ptr;
    logic [4:0]  w_word_ptr_nxt;
    logic [5:0]  r_word_count;
    logic [5:0]  w_word_count_nxt;
    logic [31:0] r_word;
    logic [31:0] w_word_nxt;
    logic        r_last;
    logic        w_last_nxt;

    logic [31:0] w_word_full;
    logic        w_accept;
    logic        w_bad_opc;

    // Shifting left keeps the first byte of a word in [31:24] once four have arrived.
    assign w_word_full = {r_word[23:0], bus.s_data};
    assign w_accept    = (r_state == ST_LOAD) && bus.s_valid;

`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    localparam logic [16:0] c_max_opcode = 17'd4;
    assign w_bad_opc = (w_word_full[31:15] > c_max_opcode);
`else
    assign w_bad_opc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_byte_idx   <= 2'd0;
            r_word_ptr   <= 5'd0;
            r_word_count <= 6'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_word_ptr   <= w_word_ptr_nxt;
            r_word_count <= w_word_count_nxt;
            r_word       <= w_word_nxt;
            r_last       <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_idx_nxt   = r_byte_idx;
        w_word_ptr_nxt   = r_word_ptr;
        w_word_count_nxt = r_word_count;
        w_word_nxt       = r_word;
        w_last_nxt       = r_last;

        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    w_word_nxt     = w_word_full;
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        w_last_nxt  = bus.s_last;
                        w_state_nxt = w_bad_opc ? ST_ERR : ST_WRITE;
                    end else if (bus.s_last) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_WRITE: begin
                w_word_ptr_nxt   = r_word_ptr + 5'd1;
                w_word_count_nxt = r_word_count + 6'd1;
                // Address 31 is the final slot, so a full memory ends the load.
                if (r_last || (r_word_ptr == c_last_addr)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    assign bus.s_ready    = (r_state == ST_LOAD);
    assign bus.wr_en      = (r_state == ST_WRITE);
    assign bus.wr_addr    = r_word_ptr;
    assign bus.wr_data    = r_word;
    assign bus.cpu_hold   = (r_state != ST_DONE);
    assign bus.load_done  = (r_state == ST_DONE);
    assign bus.load_err   = (r_state == ST_ERR);
    assign bus.word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Randomized self-checking bench for instr_loader against a
//                whole-program reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    localparam bit C_OPC_CHECK = 1'b1;
`else
    localparam bit C_OPC_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_loader_if bus ();

    instr_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_data[$];
    bit         q_last[$];
    bit         pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_s_ready",    bus.s_ready,    1);
        check("rst_wr_en",      bus.wr_en,      0);
        check("rst_cpu_hold",   bus.cpu_hold,   1);
        check("rst_load_done",  bus.load_done,  0);
        check("rst_load_err",   bus.load_err,   0);
        check("rst_word_count", bus.word_count, 0);
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit last_on_b3);
        for (int b = 0; b < 4; b++) begin
            q_data.push_back(w[31 - 8*b -: 8]);
            q_last.push_back(last_on_b3 && (b == 3));
        end
    endtask

    // Reference: walk the byte stream with the loader's rules to get the writes,
    // the final outcome (0 loading, 1 done, 2 error) and how many bytes are taken.
    task automatic run_program(input int pct, input bit use_pat);
        logic [31:0] exp_data[$];
        logic [31:0] w;
        int exp_end;
        int exp_consumed;
        int idx;
        int cyc;
        int n4;
        int nwr;
        bit finished;
        bit v;

        exp_end = 0;
        exp_consumed = 0;
        w = 32'd0;
        for (int i = 0; i < q_data.size(); i++) begin
            exp_consumed = i + 1;
            w = {w[23:0], q_data[i]};
            if ((i % 4) != 3) begin
                if (q_last[i]) begin
                    exp_end = 2;
                    break;
                end
            end else begin
                if (C_OPC_CHECK && (w[31:15] > 17'd4)) begin
                    exp_end = 2;
                    break;
                end
                exp_data.push_back(w);
                if (q_last[i] || (exp_data.size() == 32)) begin
                    exp_end = 1;
                    break;
                end
            end
        end

        idx = 0;
        cyc = 0;
        n4 = -10;
        nwr = 0;
        finished = 1'b0;
        while (!finished && (cyc < 3000)) begin
            if (bus.load_done && bus.load_err) check("both_flags", 1, 0);
            if (bus.wr_en) begin
                check("wr_latency", cyc, n4 + 1);
                check("ready_in_write", bus.s_ready, 0);
                if (nwr < exp_data.size()) begin
                    check("wr_addr", bus.wr_addr, nwr);
                    check("wr_data", bus.wr_data, exp_data[nwr]);
                end else begin
                    check("unexpected_write", bus.wr_en, 0);
                end
                nwr++;
            end
            if (bus.load_done || bus.load_err) begin
                finished = 1'b1;
            end else begin
                v = use_pat ? pat[cyc % 7] : ($urandom_range(0, 99) < pct);
                if (idx < q_data.size()) begin
                    bus.s_valid = v;
                    bus.s_data  = q_data[idx];
                    bus.s_last  = q_last[idx];
                    if (v && bus.s_ready) begin
                        if ((idx % 4) == 3) n4 = cyc;
                        idx++;
                    end
                end else begin
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                end
                step();
                cyc++;
            end
        end
        check("timeout", finished, 1);

        // Once finished, offered bytes must be refused and nothing written.
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            bus.s_last  = 1'b0;
            step();
            check("post_s_ready", bus.s_ready, 0);
            check("post_wr_en",   bus.wr_en,   0);
        end
        bus.s_valid = 1'b0;

        check("end_load_done",  bus.load_done,  (exp_end == 1));
        check("end_load_err",   bus.load_err,   (exp_end == 2));
        check("end_cpu_hold",   bus.cpu_hold,   (exp_end != 1));
        check("end_word_count", bus.word_count, exp_data.size());
        check("end_num_writes", nwr,            exp_data.size());
        check("end_accepted",   idx,            exp_consumed);
    endtask

    task automatic gen_random();
        int nwords;
        int err_word;
        int err_byte;
        logic [16:0] opc;
        logic [31:0] word;
        q_data.delete();
        q_last.delete();
        nwords   = $urandom_range(1, 8);
        err_word = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nwords - 1) : -1;
        err_byte = $urandom_range(0, 2);
        for (int wi = 0; wi < nwords; wi++) begin
            opc  = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(5, 131071))
                                               : 17'($urandom_range(0, 4));
            word = {opc, 15'($urandom)};
            for (int b = 0; b < 4; b++) begin
                q_data.push_back(word[31 - 8*b -: 8]);
                q_last.push_back(((wi == err_word) && (b == err_byte)) ||
                                 ((wi == nwords - 1) && (b == 3)));
                if ((wi == err_word) && (b == err_byte)) return;
            end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.s_last  = 1'b0;

        // Single word with gap pattern 1,0,0,1,1,0,1
        do_reset();
        q_data.delete(); q_last.delete();
        push_word(32'h0000_8C22, 1'b1);
        run_program(100, 1'b1);

        // Full memory plus an extra word that must not be taken
        do_reset();
        q_data.delete(); q_last.delete();
        for (int i = 0; i < 33; i++) begin
            push_word({17'($urandom_range(0, 4)), 15'($urandom)}, 1'b0);
        end
        run_program(100, 1'b0);

        // Early last on byte 2
        do_reset();
        q_data.delete(); q_last.delete();
        q_data.push_back(8'h00); q_last.push_back(1'b0);
        q_data.push_back(8'h01); q_last.push_back(1'b1);
        run_program(70, 1'b0);

        // Opcode 5
        do_reset();
        q_data.delete(); q_last.delete();
        push_word(32'h0002_8000, 1'b1);
        run_program(70, 1'b0);

        // Reset after two bytes, asserted together with another valid byte
        do_reset();
        bus.s_valid = 1'b1; bus.s_data = 8'h12; bus.s_last = 1'b0;
        step();
        bus.s_data = 8'h34;
        step();
        rst = 1'b1;
        bus.s_data = 8'h56; bus.s_last = 1'b1;
        step();
        check("midrst_word_count", bus.word_count, 0);
        check("midrst_wr_en",      bus.wr_en,      0);
        check("midrst_load_err",   bus.load_err,   0);
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        q_data.delete(); q_last.delete();
        push_word(32'h0001_0443, 1'b1);
        run_program(80, 1'b0);

        // Random programs with random gaps
        for (int r = 0; r < 8; r++) begin
            do_reset();
            gen_random();
            run_program($urandom_range(30, 100), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
